// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl: sequences 1-4 byte memory requests onto an 8-bit multiplexed address/data bus
module ext_bus_ctrl #(
    parameter int          WAIT_CYCLES = 2,
    parameter logic [15:0] ROM_END     = 16'h8000
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [23:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [2:0]  byteCount,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic        dataOutReady,
    output logic        dataInReady,
    output logic [7:0]  busOut,
    output logic        busOe,
    input  logic [7:0]  busIn,
    output logic        addressLatch0,
    output logic        addressLatch1,
    output logic        RAMChipEnable,
    output logic        RAMRead,
    output logic        RAMWrite,
    output logic        ROMChipEnable,
    output logic        ROMRead
);
    localparam int            WW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ADDR_LO, ADDR_HI, ACCESS, RECOVER, DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   addr_q, addr_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          wr_q, wr_d;
    logic [1:0]    idx_q, idx_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   data_out_q, data_out_d;
    logic [7:0]    bus_out_q, bus_out_d;
    logic          bus_oe_q, bus_oe_d;
    logic          out_rdy_q, out_rdy_d;
    logic          in_rdy_q, in_rdy_d;
    logic          al0_q, al0_d;
    logic          al1_q, al1_d;
    logic          ram_ce_q, ram_ce_d;
    logic          ram_rd_q, ram_rd_d;
    logic          ram_wr_q, ram_wr_d;
    logic          rom_ce_q, rom_ce_d;
    logic          rom_rd_q, rom_rd_d;
    logic [15:0]   byte_addr;
    logic          is_rom;
    logic          in_access;
    logic          wr_drive;

    // Transfer sequencing: request capture, byte stepping, wait counting and read-data capture
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        wr_d       = wr_q;
        idx_d      = idx_q;
        wait_d     = wait_q;
        data_out_d = data_out_q;
        case (state_q)
            IDLE: begin
                if (read || write) begin
                    wr_d       = !read;
                    addr_d     = address[15:0];
                    cnt_d      = (byteCount > 3'd4) ? 3'd4 : byteCount;
                    data_d     = dataIn;
                    idx_d      = 2'd0;
                    data_out_d = read ? 32'd0 : data_out_q;
                    state_d    = (byteCount == 3'd0) ? DONE : ADDR_LO;
                end
            end
            ADDR_LO: state_d = ADDR_HI;
            ADDR_HI: begin
                wait_d  = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = RECOVER;
                    if (!wr_q) data_out_d[{idx_q, 3'b000} +: 8] = busIn;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            RECOVER: begin
                if ({1'b0, idx_q} + 3'd1 < cnt_q) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = ADDR_LO;
                end else begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values for the state being entered, so every pin comes straight from a flop
    always_comb begin
        byte_addr = addr_d + {14'd0, idx_d};
        is_rom    = byte_addr < ROM_END;
        in_access = state_d == ACCESS;
        wr_drive  = wr_d && (in_access || state_d == RECOVER);
        al0_d     = state_d == ADDR_LO;
        al1_d     = state_d == ADDR_HI;
        ram_ce_d  = in_access && !is_rom;
        ram_rd_d  = in_access && !is_rom && !wr_d;
        ram_wr_d  = in_access && !is_rom && wr_d;
        rom_ce_d  = in_access && is_rom && !wr_d;
        rom_rd_d  = in_access && is_rom && !wr_d;
        bus_oe_d  = al0_d || al1_d || wr_drive;
        bus_out_d = al0_d ? byte_addr[7:0] : al1_d ? byte_addr[15:8] :
                    wr_drive ? data_d[{idx_d, 3'b000} +: 8] : 8'h00;
        out_rdy_d = state_d == DONE && !wr_d;
        in_rdy_d  = state_d == DONE && wr_d;
    end

    // State and output registers; reset clears everything at once, including mid-transfer
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wait_q     <= '0;
            data_out_q <= '0;
            bus_out_q  <= '0;
            bus_oe_q   <= 1'b0;
            out_rdy_q  <= 1'b0;
            in_rdy_q   <= 1'b0;
            al0_q      <= 1'b0;
            al1_q      <= 1'b0;
            ram_ce_q   <= 1'b0;
            ram_rd_q   <= 1'b0;
            ram_wr_q   <= 1'b0;
            rom_ce_q   <= 1'b0;
            rom_rd_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
            idx_q      <= idx_d;
            wait_q     <= wait_d;
            data_out_q <= data_out_d;
            bus_out_q  <= bus_out_d;
            bus_oe_q   <= bus_oe_d;
            out_rdy_q  <= out_rdy_d;
            in_rdy_q   <= in_rdy_d;
            al0_q      <= al0_d;
            al1_q      <= al1_d;
            ram_ce_q   <= ram_ce_d;
            ram_rd_q   <= ram_rd_d;
            ram_wr_q   <= ram_wr_d;
            rom_ce_q   <= rom_ce_d;
            rom_rd_q   <= rom_rd_d;
        end
    end

    assign dataOut       = data_out_q;
    assign dataOutReady  = out_rdy_q;
    assign dataInReady   = in_rdy_q;
    assign busOut        = bus_out_q;
    assign busOe         = bus_oe_q;
    assign addressLatch0 = al0_q;
    assign addressLatch1 = al1_q;
    assign RAMChipEnable = ram_ce_q;
    assign RAMRead       = ram_rd_q;
    assign RAMWrite      = ram_wr_q;
    assign ROMChipEnable = rom_ce_q;
    assign ROMRead       = rom_rd_q;
endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl: randomized and directed transfers checked against a cycle-phase reference model
module tb_ext_bus_ctrl;
    localparam int          W       = 2;
    localparam int          BYTE_T  = 3 + W;
    localparam logic [15:0] ROM_END = 16'h8000;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic [23:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [2:0]  byteCount = '0;
    logic [31:0] dataIn = '0;
    logic [31:0] dataOut;
    logic        dataOutReady;
    logic        dataInReady;
    logic [7:0]  busOut;
    logic        busOe;
    logic [7:0]  busIn = '0;
    logic        addressLatch0;
    logic        addressLatch1;
    logic        RAMChipEnable;
    logic        RAMRead;
    logic        RAMWrite;
    logic        ROMChipEnable;
    logic        ROMRead;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_dout = '0;

    always #5 clk = ~clk;

    ext_bus_ctrl #(.WAIT_CYCLES(W), .ROM_END(ROM_END)) dut (
        .clk(clk), .nrst(nrst), .address(address), .read(read), .write(write),
        .byteCount(byteCount), .dataIn(dataIn), .dataOut(dataOut),
        .dataOutReady(dataOutReady), .dataInReady(dataInReady), .busOut(busOut),
        .busOe(busOe), .busIn(busIn), .addressLatch0(addressLatch0),
        .addressLatch1(addressLatch1), .RAMChipEnable(RAMChipEnable), .RAMRead(RAMRead),
        .RAMWrite(RAMWrite), .ROMChipEnable(ROMChipEnable), .ROMRead(ROMRead)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] ctrl_now();
        return {addressLatch0, addressLatch1, RAMChipEnable, RAMRead, RAMWrite,
                ROMChipEnable, ROMRead, busOe, dataOutReady, dataInReady};
    endfunction

    function automatic logic [49:0] all_outs();
        return {dataOut, busOut, ctrl_now()};
    endfunction

    // Expected control pins for cycle c after the request: each byte occupies BYTE_T cycles
    // (latch lo, latch hi, W access cycles, recover), and ready follows the last byte.
    function automatic logic [9:0] exp_ctrl(int c, bit wr, logic [15:0] base, int n);
        int b, p;
        logic [15:0] a;
        bit rom, acc, rec;
        if (c == 1 + n * BYTE_T) return wr ? 10'b0000000001 : 10'b0000000010;
        if (c < 1 || c > 1 + n * BYTE_T) return 10'b0;
        b   = (c - 1) / BYTE_T;
        p   = (c - 1) % BYTE_T;
        a   = base + 16'(b);
        rom = a < ROM_END;
        acc = p >= 2 && p <= W + 1;
        rec = p == W + 2;
        return {p == 0, p == 1, acc && !rom, acc && !rom && !wr, acc && !rom && wr,
                acc && rom && !wr, acc && rom && !wr, p < 2 || (wr && (acc || rec)), 1'b0, 1'b0};
    endfunction

    task automatic run_xfer(input bit rd, input bit wr, input logic [23:0] addr,
                            input logic [2:0] bc, input logic [31:0] din, input logic [31:0] rbytes);
        bit          w;
        int          n, len, b, p, nb;
        logic [15:0] a;
        w   = !rd;
        n   = (bc > 3'd4) ? 4 : int'(bc);
        len = 1 + n * BYTE_T;
        if (!w) begin
            exp_dout = '0;
            for (int k = 0; k < n; k++) exp_dout[8*k +: 8] = rbytes[8*k +: 8];
        end
        @(negedge clk);
        read = rd; write = wr; address = addr; byteCount = bc; dataIn = din;
        busIn = rbytes[7:0];
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            address = 24'($urandom); dataIn = $urandom; byteCount = 3'($urandom);
            chk("ctrl", ctrl_now(), exp_ctrl(c, w, addr[15:0], n));
            if (c < len) begin
                b = (c - 1) / BYTE_T;
                p = (c - 1) % BYTE_T;
                a = addr[15:0] + 16'(b);
                if (p == 0) chk("addr_lo", busOut, a[7:0]);
                if (p == 1) chk("addr_hi", busOut, a[15:8]);
                if (w && p >= 2 && p <= W + 1) chk("wdata", busOut, din[8*b +: 8]);
            end else begin
                read = 1'b0; write = 1'b0;
                chk("dout", dataOut, exp_dout);
            end
            nb = c / BYTE_T;
            busIn = (nb < 4) ? rbytes[8*nb +: 8] : 8'($urandom);
        end
        @(negedge clk);
        chk("idle", ctrl_now(), 10'b0);
    endtask

    // Four-byte read cut by reset during the access phase of byte 2
    task automatic reset_mid_xfer();
        int cut;
        cut = 1 + 2 * BYTE_T + 2;
        @(negedge clk);
        read = 1'b1; address = 24'h001234; byteCount = 3'd4; busIn = 8'h77;
        for (int c = 1; c <= cut; c++) begin
            @(negedge clk);
            chk("pre_rst", ctrl_now(), exp_ctrl(c, 1'b0, 16'h1234, 4));
        end
        nrst = 1'b0; read = 1'b0;
        #1 chk("rst_now", all_outs(), 50'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_hold", all_outs(), 50'b0);
        end
        nrst = 1'b1;
        exp_dout = '0;
        @(negedge clk);
        chk("rst_idle", all_outs(), 50'b0);
    endtask

    initial begin
        bit          rd, wr;
        logic [23:0] a;
        repeat (3) @(negedge clk);
        chk("reset_state", all_outs(), 50'b0);
        nrst = 1'b1;
        @(negedge clk);
        chk("post_reset", all_outs(), 50'b0);

        run_xfer(1'b1, 1'b0, 24'h129000, 3'd1, 32'h0, 32'h000000A5);
        run_xfer(1'b0, 1'b1, 24'h008000, 3'd4, 32'h44332211, 32'h0);
        run_xfer(1'b1, 1'b0, 24'h000010, 3'd2, 32'h0, 32'h0000C35A);
        run_xfer(1'b0, 1'b1, 24'h00FFFF, 3'd2, 32'hDEADBEEF, 32'h0);
        run_xfer(1'b1, 1'b1, 24'hAB7FFE, 3'd3, 32'h01020304, 32'h99887766);
        run_xfer(1'b1, 1'b0, 24'h004000, 3'd0, 32'h0, 32'h12345678);
        run_xfer(1'b0, 1'b1, 24'h004000, 3'd0, 32'hCAFEF00D, 32'h0);
        run_xfer(1'b1, 1'b0, 24'h00FFFE, 3'd7, 32'h0, 32'hF1E2D3C4);
        reset_mid_xfer();
        run_xfer(1'b1, 1'b0, 24'h00A000, 3'd1, 32'h0, 32'h0000003C);

        for (int t = 0; t < 25; t++) begin
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            a  = 24'($urandom);
            if ($urandom_range(0, 3) == 0) a[15:0] = 16'hFFFE + 16'($urandom_range(0, 3));
            run_xfer(rd, wr, a, 3'($urandom_range(0, 7)), $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
